// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 Set-2 scancode front end for the Odd/Even game keyboard port.
// Handles the E0/F0 prefix FSM, translates digit/Enter/Backspace/Esc make codes to
// 4-bit key codes, suppresses typematic repeats and queues keys in a small FIFO.
// Optional macro PS2_SEQ_TIMEOUT_EN: abort a partial prefix sequence after
// TIMEOUT_CYC idle cycles so that a lost byte cannot wedge the FSM.
//
// state   | meaning
// IDLE    | no prefix seen; next byte is a plain make code or a prefix
// EXT     | E0 seen; next byte is an extended make code or F0
// BRK     | F0 seen; next byte is a plain break code
// EXT_BRK | E0 F0 seen; next byte is an extended break code
module ps2_key_ctrl #(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [7:0]       code,
  input  logic             key_pop,
  input  logic             ovf_clr,
  output logic             key_valid,
  output logic [3:0]       key_code,
  output logic [CNT_W-1:0] key_count,
  output logic             overflow,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state, state_n;
  logic             make_ev, brk_ev, ev_ext;
  logic             map_hit;
  logic [3:0]       map_val;
  logic [8:0]       ev_key;
  logic [8:0]       held_key;
  logic             held_valid;
  logic             push_req, pop_eff, do_push, drop, full;
  logic [3:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0] count, count_n;
  logic [3:0]       head_n;
  logic             tmo_hit;

`ifdef PS2_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Down-counter reloaded on every byte and while idle; terminal count aborts the sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
    else if (code_valid || state == IDLE)
      tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
    else if (tmo_cnt != '0)
      tmo_cnt <= tmo_cnt - 1'b1;
  end

  assign tmo_hit = (state != IDLE) && (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  // Prefix FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and make/break event decode; only code_valid moves the FSM (or the abort timer).
  always_comb begin
    state_n = state;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_ext  = 1'b0;
    if (code_valid) begin
      case (state)
        IDLE: begin
          if (code == 8'hE0)      state_n = EXT;
          else if (code == 8'hF0) state_n = BRK;
          else                    make_ev = 1'b1;
        end
        EXT: begin
          if (code == 8'hF0)      state_n = EXT_BRK;
          else if (code != 8'hE0) begin
            make_ev = 1'b1;
            ev_ext  = 1'b1;
            state_n = IDLE;
          end
        end
        BRK: begin
          brk_ev  = 1'b1;
          state_n = IDLE;
        end
        default: begin
          brk_ev  = 1'b1;
          ev_ext  = 1'b1;
          state_n = IDLE;
        end
      endcase
    end else if (tmo_hit) begin
      state_n = IDLE;
    end
  end

  // Scancode to key-code translation; only keypad Enter is recognised in the extended set.
  always_comb begin
    map_hit = 1'b1;
    map_val = 4'h0;
    if (ev_ext) begin
      map_hit = (code == 8'h5A);
      map_val = 4'hA;
    end else begin
      case (code)
        8'h45, 8'h70: map_val = 4'h0;
        8'h16, 8'h69: map_val = 4'h1;
        8'h1E, 8'h72: map_val = 4'h2;
        8'h26, 8'h7A: map_val = 4'h3;
        8'h25, 8'h6B: map_val = 4'h4;
        8'h2E, 8'h73: map_val = 4'h5;
        8'h36, 8'h74: map_val = 4'h6;
        8'h3D, 8'h6C: map_val = 4'h7;
        8'h3E, 8'h75: map_val = 4'h8;
        8'h46, 8'h7D: map_val = 4'h9;
        8'h5A:        map_val = 4'hA;
        8'h66:        map_val = 4'hB;
        8'h76:        map_val = 4'hC;
        default:      map_hit = 1'b0;
      endcase
    end
  end

  assign ev_key   = {ev_ext, code};
  assign push_req = make_ev && map_hit && !(held_valid && held_key == ev_key);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_eff  = key_pop && (count != '0);
  assign do_push  = push_req && (!full || pop_eff);
  assign drop     = push_req && full && !pop_eff;

  // Held key tracks the last accepted make so typematic repeats are discarded; dropped keys still count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_key   <= '0;
      held_valid <= 1'b0;
    end else if (push_req) begin
      held_key   <= ev_key;
      held_valid <= 1'b1;
    end else if (brk_ev && held_valid && held_key == ev_key) begin
      held_valid <= 1'b0;
    end
  end

  // FIFO storage; no reset needed since key_code masks empty entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= map_val;
  end

  // Occupancy and head-of-queue look-ahead so key_code is a clean register.
  always_comb begin
    count_n = count;
    case ({do_push, pop_eff})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
    rd_ptr_n = pop_eff ? rd_ptr + 1'b1 : rd_ptr;
    head_n   = (do_push && wr_ptr == rd_ptr_n) ? map_val : mem[rd_ptr_n];
  end

  // Pointers, count, registered head and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      key_code <= 4'h0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      key_code <= (count_n == '0) ? 4'h0 : head_n;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign key_valid = (count != '0);
  assign key_count = count;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: prefix handling, key map, typematic filter,
// FIFO full/overflow behaviour, asynchronous reset and the optional sequence timeout.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       code_valid;
  logic [7:0] code;
  logic       key_pop;
  logic       ovf_clr;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] key_count;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ps2_key_ctrl #(.DEPTH(4), .CNT_W(3), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
    .key_pop(key_pop), .ovf_clr(ovf_clr), .key_valid(key_valid),
    .key_code(key_code), .key_count(key_count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    code_valid = 1'b1;
    code = b;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic pop();
    key_pop = 1'b1;
    @(negedge clk);
    key_pop = 1'b0;
  endtask

  task automatic chk_q(input string tag, input logic v, input logic [3:0] kc, input logic [2:0] n);
    chk({tag, ".valid"}, {7'd0, key_valid}, {7'd0, v});
    chk({tag, ".code"},  {4'd0, key_code},  {4'd0, kc});
    chk({tag, ".count"}, {5'd0, key_count}, {5'd0, n});
  endtask

  initial begin
    logic [7:0] mk [5];
    mk[0] = 8'h45; mk[1] = 8'h16; mk[2] = 8'h1E; mk[3] = 8'h26; mk[4] = 8'h25;
    rst = 1'b1; code_valid = 1'b0; code = 8'h00; key_pop = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk_q("reset", 1'b0, 4'h0, 3'd0);
    chk("reset.ovf", {7'd0, overflow}, 8'd0);
    chk("reset.busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: make/break of key 1, held cleared so a second make is accepted
    send(8'h16);
    chk_q("t1.make", 1'b1, 4'h1, 3'd1);
    send(8'hF0);
    chk("t1.busy_brk", {7'd0, busy}, 8'd1);
    send(8'h16);
    chk("t1.busy_idle", {7'd0, busy}, 8'd0);
    chk_q("t1.after_brk", 1'b1, 4'h1, 3'd1);
    send(8'h16);
    chk("t1.held_clr", {5'd0, key_count}, 8'd2);
    send(8'hF0); send(8'h16);
    pop();
    chk_q("t1.pop1", 1'b1, 4'h1, 3'd1);
    pop();
    chk_q("t1.pop2", 1'b0, 4'h0, 3'd0);

    // 2: typematic repeat filter
    repeat (5) send(8'h1E);
    chk_q("t2.repeat", 1'b1, 4'h2, 3'd1);
    send(8'hF0);
    chk("t2.busy_f0", {7'd0, busy}, 8'd1);
    send(8'h1E);
    chk("t2.busy_done", {7'd0, busy}, 8'd0);
    send(8'h1E);
    chk_q("t2.second", 1'b1, 4'h2, 3'd2);
    pop();
    chk_q("t2.pop1", 1'b1, 4'h2, 3'd1);
    pop();
    send(8'hF0); send(8'h1E);
    chk_q("t2.empty", 1'b0, 4'h0, 3'd0);

    // 3: extended keys
    send(8'hE0);
    chk("t3.busy_e0", {7'd0, busy}, 8'd1);
    send(8'h5A);
    chk_q("t3.kp_enter", 1'b1, 4'hA, 3'd1);
    send(8'hE0); send(8'hF0);
    chk("t3.busy_extbrk", {7'd0, busy}, 8'd1);
    send(8'h5A);
    send(8'hE0); send(8'h75);
    chk_q("t3.ext_ignored", 1'b1, 4'hA, 3'd1);
    chk("t3.busy_end", {7'd0, busy}, 8'd0);
    pop();
    chk_q("t3.empty", 1'b0, 4'h0, 3'd0);

    // 4: fill, overflow, push+pop at full, overflow clear
    for (int k = 0; k < 5; k++) begin
      send(mk[k]); send(8'hF0); send(mk[k]);
    end
    chk_q("t4.full", 1'b1, 4'h0, 3'd4);
    chk("t4.ovf", {7'd0, overflow}, 8'd1);
    code_valid = 1'b1; code = 8'h2E; key_pop = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; key_pop = 1'b0;
    chk_q("t4.pushpop_full", 1'b1, 4'h1, 3'd4);
    chk("t4.ovf_kept", {7'd0, overflow}, 8'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t4.ovf_clr", {7'd0, overflow}, 8'd0);
    pop();
    chk("t4.e2", {4'd0, key_code}, 8'h2);
    pop();
    chk("t4.e3", {4'd0, key_code}, 8'h3);
    pop();
    chk_q("t4.tail", 1'b1, 4'h5, 3'd1);
    pop();
    chk_q("t4.drained", 1'b0, 4'h0, 3'd0);

    // 5: pop on empty with push, then async reset mid-sequence
    code_valid = 1'b1; code = 8'h3D; key_pop = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; key_pop = 1'b0;
    chk_q("t5.pop_empty_push", 1'b1, 4'h7, 3'd1);
    send(8'hE0);
    chk("t5.busy_e0", {7'd0, busy}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk_q("t5.rst", 1'b0, 4'h0, 3'd0);
    chk("t5.rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h16);
    chk_q("t5.after_rst", 1'b1, 4'h1, 3'd1);
    send(8'hF0); send(8'h16);
    pop();

    // 6: prefix timeout (only aborts when the feature is built in)
    send(8'hF0);
    repeat (100) @(negedge clk);
`ifdef PS2_SEQ_TIMEOUT_EN
    chk("t6.busy_idle", {7'd0, busy}, 8'd0);
    send(8'h16);
    chk_q("t6.aborted", 1'b1, 4'h1, 3'd1);
`else
    chk("t6.busy_wait", {7'd0, busy}, 8'd1);
    send(8'h16);
    chk_q("t6.break", 1'b0, 4'h0, 3'd0);
`endif
    chk("t6.busy_end", {7'd0, busy}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
